// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 DVP capture path:
//   - cap_state_t : capture FSM encoding (S_CFG / S_SKIP / S_SYNC / S_CAP)
//   - default VGA geometry (640 x 480)
//   - RGB565 field positions and a helper that packs two DVP bytes
// ---------------------------------------------------------------------------
package ov7670_pkg;

  typedef enum logic [1:0] {
    S_CFG  = 2'd0,  // waiting for sensor configuration
    S_SKIP = 2'd1,  // discarding settling frames
    S_SYNC = 2'd2,  // waiting for the start of a frame
    S_CAP  = 2'd3   // capturing pixels
  } cap_state_t;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // The sensor sends R[4:0]G[5:3] first, then G[2:0]B[4:0]; placing the
  // fields explicitly documents the split even though it equals {hi, lo}.
  function automatic logic [15:0] rgb565_pack(input logic [7:0] hi,
                                               input logic [7:0] lo);
    logic [15:0] pix;
    pix = '0;
    pix[RGB_R_MSB:RGB_R_LSB] = hi[7:3];
    pix[RGB_G_MSB:RGB_G_LSB] = {hi[2:0], lo[7:5]};
    pix[RGB_B_MSB:RGB_B_LSB] = lo[4:0];
    return pix;
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// ---------------------------------------------------------------------------
// dvp_sync_edge
// Input register stage for the OV7670 DVP bus plus edge detectors.
// Edges are found between the registered copy and a one-cycle delayed copy.
// Ports:
//   CLK, RST_N         : pixel clock, async active-low reset
//   vsync, href, din   : raw camera inputs
//   href_q, din_q      : registered line-valid and data
//   vsync_rise/fall    : one-cycle pulses on registered VSYNC edges
//   href_fall          : one-cycle pulse on registered HREF falling edge
// ---------------------------------------------------------------------------
module dvp_sync_edge (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] din,
  output logic       href_q,
  output logic [7:0] din_q,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  logic vsync_q;
  logic vsync_d;
  logic href_d;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, keeping the delay chain intact.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      din_q   <= '0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      din_q   <= din;
      vsync_d <= vsync_q;
      href_d  <= href_q;
    end
  end

  assign vsync_rise =  vsync_q & ~vsync_d;
  assign vsync_fall = ~vsync_q &  vsync_d;
  assign href_fall  = ~href_q  &  href_d;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// ---------------------------------------------------------------------------
// ov7670_pixel_capture
// Captures the OV7670 DVP byte stream once configuration is done, pairs
// bytes into RGB565 pixels and tags them with X/Y coordinates.
// Parameters: H_ACTIVE, V_ACTIVE (accepted geometry), SKIP_FRAMES (settling
//   frames dropped after CFG_DONE rises), X_W, Y_W (coordinate widths).
// Ports:
//   CLK, RST_N            : camera PCLK, async active-low reset
//   CFG_DONE              : sensor configuration complete (level)
//   VSYNC, HREF, DIN      : DVP inputs
//   PIX_DATA/X/Y, PIX_VALID : pixel and its coordinates, one-cycle strobe
//   FRAME_START           : one-cycle pulse when a captured frame begins
//   FRAME_CNT             : captured-frame counter (wraps)
// Optional macro CAPTURE_ERR_CHECK_EN adds sticky LINE_ERR / FRAME_ERR
// outputs, cleared on FRAME_START.
// ---------------------------------------------------------------------------
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE    = V_ACTIVE_DEFAULT,
  parameter int SKIP_FRAMES = 10,
  parameter int X_W         = 10,
  parameter int Y_W         = 9
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CFG_DONE,
  input  logic           VSYNC,
  input  logic           HREF,
  input  logic [7:0]     DIN,
  output logic [15:0]    PIX_DATA,
  output logic           PIX_VALID,
  output logic [X_W-1:0] PIX_X,
  output logic [Y_W-1:0] PIX_Y,
  output logic           FRAME_START,
  output logic [7:0]     FRAME_CNT
`ifdef CAPTURE_ERR_CHECK_EN
  ,
  output logic           LINE_ERR,
  output logic           FRAME_ERR
`endif
);

  // Skip counter only needs to reach SKIP_FRAMES-1; the final rise leaves
  // S_SKIP directly.
  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST =
    SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  // Counters carry one extra bit so they can hold the saturation value
  // even when the active size is a power of two.
  localparam logic [X_W:0] H_MAX = (X_W+1)'(H_ACTIVE);
  localparam logic [Y_W:0] V_MAX = (Y_W+1)'(V_ACTIVE);

  logic       href_q;
  logic [7:0] din_q;
  logic       vsync_rise;
  logic       vsync_fall;
  logic       href_fall;

  dvp_sync_edge u_sync (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .vsync      (VSYNC),
    .href       (HREF),
    .din        (DIN),
    .href_q     (href_q),
    .din_q      (din_q),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  cap_state_t        state;
  cap_state_t        state_nxt;
  logic [SKIP_W-1:0] skip_cnt;
  logic              toggle;
  logic [7:0]        hi_byte;
  logic [X_W:0]      col;
  logic [Y_W:0]      row;
  logic [Y_W:0]      row_nxt;

  logic cap_en;
  logic frame_begin;
  logic frame_end;
  logic line_end;
  logic pix_form;
  logic pix_in_range;

  // Dropping CFG_DONE freezes capture in the same cycle it is seen.
  assign cap_en       = (state == S_CAP) && CFG_DONE;
  assign frame_begin  = (state == S_SYNC) && CFG_DONE && vsync_fall;
  assign frame_end    = cap_en && vsync_rise;
  assign line_end     = cap_en && href_fall;
  assign pix_form     = cap_en && href_q && toggle;
  assign pix_in_range = (col < H_MAX) && (row < V_MAX);

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_CFG;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (!CFG_DONE) begin
      state_nxt = S_CFG;
    end else begin
      unique case (state)
        S_CFG:  state_nxt = (SKIP_FRAMES == 0) ? S_SYNC : S_SKIP;
        S_SKIP: if (vsync_rise && (skip_cnt == SKIP_LAST)) state_nxt = S_SYNC;
        S_SYNC: if (vsync_fall) state_nxt = S_CAP;
        S_CAP:  if (vsync_rise) state_nxt = S_SYNC;
        default: state_nxt = S_CFG;
      endcase
    end
  end

  // Settling-frame counter; held clear outside S_SKIP so it restarts on
  // every CFG_DONE rise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                skip_cnt <= '0;
    else if (state != S_SKIP)  skip_cnt <= '0;
    else if (vsync_rise)       skip_cnt <= skip_cnt + 1'b1;
  end

  // A line counts towards the row only if it produced at least one pixel;
  // col never wraps back to 0 mid-line, so col != 0 is that indicator.
  always_comb begin
    row_nxt = row;
    if (line_end && (col != '0) && (row < V_MAX)) row_nxt = row + 1'b1;
  end

  // ---------------- byte pairing and coordinates ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      toggle  <= 1'b0;
      hi_byte <= '0;
      col     <= '0;
      row     <= '0;
    end else if (frame_begin) begin
      toggle <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else if (cap_en) begin
      if (href_q) begin
        if (!toggle) begin
          hi_byte <= din_q;
          toggle  <= 1'b1;
        end else begin
          toggle <= 1'b0;
          if (col < H_MAX) col <= col + 1'b1;
        end
      end else if (href_fall) begin
        // An odd trailing byte is discarded by clearing the toggle.
        toggle <= 1'b0;
        col    <= '0;
      end
      row <= row_nxt;
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PIX_DATA    <= '0;
      PIX_VALID   <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= '0;
    end else begin
      PIX_VALID   <= pix_form && pix_in_range;
      FRAME_START <= frame_begin;
      if (frame_begin) begin
        PIX_X <= '0;
        PIX_Y <= '0;
      end else if (pix_form && pix_in_range) begin
        PIX_DATA <= rgb565_pack(hi_byte, din_q);
        PIX_X    <= col[X_W-1:0];
        PIX_Y    <= row[Y_W-1:0];
      end
      if (frame_end) FRAME_CNT <= FRAME_CNT + 8'd1;
    end
  end

`ifdef CAPTURE_ERR_CHECK_EN
  // Saturating counters cannot tell "exactly H_ACTIVE" from "more than
  // H_ACTIVE", so overflow is tracked separately for both axes.
  logic col_ovf;
  logic row_ovf;
  logic line_over;

  assign line_over = line_end && (col != '0) && (row == V_MAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LINE_ERR  <= 1'b0;
      FRAME_ERR <= 1'b0;
      col_ovf   <= 1'b0;
      row_ovf   <= 1'b0;
    end else if (frame_begin) begin
      LINE_ERR  <= 1'b0;
      FRAME_ERR <= 1'b0;
      col_ovf   <= 1'b0;
      row_ovf   <= 1'b0;
    end else if (cap_en) begin
      if (pix_form && (col == H_MAX)) col_ovf <= 1'b1;
      if (line_end) begin
        col_ovf <= 1'b0;
        if ((col != H_MAX) || col_ovf || toggle) LINE_ERR <= 1'b1;
      end
      if (line_over) row_ovf <= 1'b1;
      if (frame_end && ((row_nxt != V_MAX) || row_ovf || line_over))
        FRAME_ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// ---------------------------------------------------------------------------
// tb_ov7670_pixel_capture
// Directed bench for ov7670_pixel_capture with a small 4x3 geometry and two
// settling frames. The driver pushes each expected pixel into a scoreboard
// as it sends the bytes; a monitor pops and compares on every PIX_VALID.
// Define CAPTURE_ERR_CHECK_EN to also exercise LINE_ERR / FRAME_ERR.
// ---------------------------------------------------------------------------
module tb_ov7670_pixel_capture;
  import ov7670_pkg::*;

  localparam int H_T    = 4;
  localparam int V_T    = 3;
  localparam int SKIP_T = 2;
  localparam int XW     = 3;
  localparam int YW     = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CFG_DONE = 1'b0;
  logic          VSYNC = 1'b0;
  logic          HREF = 1'b0;
  logic [7:0]    DIN = 8'h00;
  logic [15:0]   PIX_DATA;
  logic          PIX_VALID;
  logic [XW-1:0] PIX_X;
  logic [YW-1:0] PIX_Y;
  logic          FRAME_START;
  logic [7:0]    FRAME_CNT;
`ifdef CAPTURE_ERR_CHECK_EN
  logic          LINE_ERR;
  logic          FRAME_ERR;
`endif

  ov7670_pixel_capture #(
    .H_ACTIVE    (H_T),
    .V_ACTIVE    (V_T),
    .SKIP_FRAMES (SKIP_T),
    .X_W         (XW),
    .Y_W         (YW)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CFG_DONE    (CFG_DONE),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .DIN         (DIN),
    .PIX_DATA    (PIX_DATA),
    .PIX_VALID   (PIX_VALID),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .FRAME_START (FRAME_START),
    .FRAME_CNT   (FRAME_CNT)
`ifdef CAPTURE_ERR_CHECK_EN
    ,
    .LINE_ERR    (LINE_ERR),
    .FRAME_ERR   (FRAME_ERR)
`endif
  );

  typedef struct {
    logic [15:0]   data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          lat;
  } pix_t;

  pix_t sb[$];
  pix_t exp_px;
  int   n_pass = 0;
  int   n_total = 0;
  int   fs_cnt = 0;
  int   cyc = 0;
  int   t_lat = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge CLK);
    if (FRAME_START) fs_cnt++;
    if (PIX_VALID) begin
      if (sb.size() == 0) begin
        check("unexpected_pix", 32'(PIX_VALID), 32'd0);
      end else begin
        exp_px = sb.pop_front();
        check("pix_data", 32'(PIX_DATA), 32'(exp_px.data));
        check("pix_x",    32'(PIX_X),    32'(exp_px.x));
        check("pix_y",    32'(PIX_Y),    32'(exp_px.y));
        if (exp_px.lat) check("pix_latency", 32'(cyc - t_lat), 32'd2);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  function automatic logic [7:0] pat(input int f, input int r, input int i);
    return 8'((f * 37 + r * 19 + i * 3 + 1) & 255);
  endfunction

  // Sends one HREF line; when cap is set, pushes every pixel that should
  // survive the H/V window. vs_end raises VSYNC on the same edge HREF falls.
  task automatic send_line(input int f, input int r, input int nbytes,
                           input bit cap, input bit vs_end, input bit first_px);
    logic [7:0] b;
    logic [7:0] hi;
    pix_t       px;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = pat(f, r, i);
      if (first_px && i == 0) b = 8'hF8;
      if (first_px && i == 1) b = 8'h1F;
      @(negedge CLK);
      HREF = 1'b1;
      DIN  = b;
      if (i % 2 == 0) begin
        hi = b;
      end else if (cap && (i / 2) < H_T && r < V_T) begin
        if (first_px && i == 1) t_lat = cyc;
        px.data = {hi, b};
        px.x    = XW'(i / 2);
        px.y    = YW'(r);
        px.lat  = first_px && (i == 1);
        sb.push_back(px);
      end
    end
    @(negedge CLK);
    HREF = 1'b0;
    DIN  = 8'h00;
    if (vs_end) VSYNC = 1'b1;
    else repeat (3) @(negedge CLK);
  endtask

  task automatic send_lines(input int f, input int nlines, input bit cap);
    for (int r = 0; r < nlines; r++) send_line(f, r, 2 * H_T, cap, 1'b0, 1'b0);
  endtask

  task automatic vsync_high();
    @(negedge CLK);
    VSYNC = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic vsync_low();
    @(negedge CLK);
    VSYNC = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_data"},    32'(PIX_DATA),    32'd0);
    check({tag, "_pix_valid"},   32'(PIX_VALID),   32'd0);
    check({tag, "_pix_x"},       32'(PIX_X),       32'd0);
    check({tag, "_pix_y"},       32'(PIX_Y),       32'd0);
    check({tag, "_frame_start"}, 32'(FRAME_START), 32'd0);
    check({tag, "_frame_cnt"},   32'(FRAME_CNT),   32'd0);
    check({tag, "_state"},       32'(dut.state),   32'(S_CFG));
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST_N = 1'b1;

    // Configuration not done: a whole frame is ignored.
    send_lines(0, V_T, 1'b0);
    vsync_high();
    check("cfg0_frame_cnt", 32'(FRAME_CNT), 32'd0);
    vsync_low();
    check("cfg0_frame_start", 32'(fs_cnt), 32'd0);

    // Two settling frames, then capture starts on the second VSYNC fall.
    CFG_DONE = 1'b1;
    repeat (2) @(negedge CLK);
    send_lines(1, V_T, 1'b0);
    vsync_high();
    vsync_low();
    check("skip1_frame_start", 32'(fs_cnt), 32'd0);
    send_lines(2, V_T, 1'b0);
    vsync_high();
    check("skip2_frame_cnt", 32'(FRAME_CNT), 32'd0);
    vsync_low();
    check("skip2_frame_start", 32'(fs_cnt), 32'd1);

    // Frame 3: clean frame, first pixel 0xF8,0x1F with latency check.
    send_line(3, 0, 2 * H_T, 1'b1, 1'b0, 1'b1);
    for (int r = 1; r < V_T; r++) send_line(3, r, 2 * H_T, 1'b1, 1'b0, 1'b0);
    vsync_high();
    check("f3_frame_cnt", 32'(FRAME_CNT), 32'd1);
    check("f3_drained", 32'(sb.size()), 32'd0);
`ifdef CAPTURE_ERR_CHECK_EN
    check("f3_line_err",  32'(LINE_ERR),  32'd0);
    check("f3_frame_err", 32'(FRAME_ERR), 32'd0);
`endif
    vsync_low();
    check("f3_frame_start", 32'(fs_cnt), 32'd2);

    // Frame 4: overlong odd line, then too many lines.
    send_line(4, 0, 4 * H_T + 1, 1'b1, 1'b0, 1'b0);
    for (int r = 1; r < V_T + 2; r++) send_line(4, r, 2 * H_T, 1'b1, 1'b0, 1'b0);
    vsync_high();
    check("f4_frame_cnt", 32'(FRAME_CNT), 32'd2);
    check("f4_drained", 32'(sb.size()), 32'd0);
`ifdef CAPTURE_ERR_CHECK_EN
    check("f4_line_err",  32'(LINE_ERR),  32'd1);
    check("f4_frame_err", 32'(FRAME_ERR), 32'd1);
`endif
    vsync_low();
`ifdef CAPTURE_ERR_CHECK_EN
    check("f4_err_cleared", 32'({LINE_ERR, FRAME_ERR}), 32'd0);
`endif

    // Frame 5: last HREF fall coincides with the VSYNC rise.
    for (int r = 0; r < V_T - 1; r++) send_line(5, r, 2 * H_T, 1'b1, 1'b0, 1'b0);
    send_line(5, V_T - 1, 2 * H_T, 1'b1, 1'b1, 1'b0);
    vsync_high();
    check("f5_frame_cnt", 32'(FRAME_CNT), 32'd3);
`ifdef CAPTURE_ERR_CHECK_EN
    check("f5_line_err",  32'(LINE_ERR),  32'd0);
    check("f5_frame_err", 32'(FRAME_ERR), 32'd0);
`endif
    vsync_low();
    check("f5_frame_start", 32'(fs_cnt), 32'd4);

    // Reset pulsed in the middle of a line.
    @(negedge CLK);
    HREF = 1'b1;
    DIN  = 8'hAA;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_all_zero("midline_rst");
    @(negedge CLK);
    HREF = 1'b0;
    DIN  = 8'h00;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Settling frames again after reset.
    send_lines(6, V_T, 1'b0);
    vsync_high();
    vsync_low();
    send_lines(7, V_T, 1'b0);
    vsync_high();
    vsync_low();
    check("rst_skip_frame_start", 32'(fs_cnt), 32'd5);

    // Frame 8: one good line, then CFG_DONE drops as a pixel completes.
    send_line(8, 0, 2 * H_T, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    HREF = 1'b1;
    DIN  = 8'h12;
    @(negedge CLK);
    DIN  = 8'h34;
    @(negedge CLK);
    DIN      = 8'h56;
    CFG_DONE = 1'b0;
    @(negedge CLK);
    check("cfg_drop_pix_valid", 32'(PIX_VALID), 32'd0);
    check("cfg_drop_state",     32'(dut.state), 32'(S_CFG));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      DIN = DIN + 8'd1;
    end
    @(negedge CLK);
    HREF = 1'b0;
    repeat (5) @(negedge CLK);
    check("final_drained",   32'(sb.size()), 32'd0);
    check("final_frame_cnt", 32'(FRAME_CNT), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
